// File: rtl/cordic_output_stage.sv
// Output stage of the pipelined CORDIC rotator: gain compensation, quadrant fix, FWFT result FIFO.
// Define CORDIC_GAIN_COMP_EN to enable the K ~= 0.607254 shift-add gain compensation.
module cordic_output_stage #(
    parameter int WIDTH  = 32,
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    valid_in,
    input  logic signed [WIDTH-1:0] x_in,
    input  logic signed [WIDTH-1:0] y_in,
    input  logic signed [WIDTH-1:0] z_in,
    input  logic        [1:0]       quad_in,
    input  logic                    out_ready,
    output logic                    out_valid,
    output logic signed [WIDTH-1:0] cos_out,
    output logic signed [WIDTH-1:0] sin_out,
    output logic signed [WIDTH-1:0] z_res,
    output logic        [ADDR_W:0]  fifo_count,
    output logic                    overflow
);

    localparam logic [ADDR_W:0] FULL_CNT = DEPTH[ADDR_W:0];

`ifdef CORDIC_GAIN_COMP_EN
    function automatic logic signed [WIDTH-1:0] gain_a(input logic signed [WIDTH-1:0] v);
        return (v >>> 1) + (v >>> 3) - (v >>> 6) - (v >>> 9);
    endfunction

    function automatic logic signed [WIDTH-1:0] gain_b(input logic signed [WIDTH-1:0] a,
                                                       input logic signed [WIDTH-1:0] v);
        return a - (v >>> 13) - (v >>> 15) - (v >>> 16);
    endfunction
`endif

    // Two's complement negation; the most negative value wraps onto itself.
    function automatic logic signed [WIDTH-1:0] neg(input logic signed [WIDTH-1:0] v);
        return -v;
    endfunction

    logic                    vld_p0, vld_p1, vld_p2;
    logic signed [WIDTH-1:0] x_p0, y_p0, z_p0;
    logic        [1:0]       quad_p0, quad_p1, quad_p2;
    logic signed [WIDTH-1:0] xa_p1, ya_p1, z_p1;
`ifdef CORDIC_GAIN_COMP_EN
    logic signed [WIDTH-1:0] x_p1, y_p1;
`endif
    logic signed [WIDTH-1:0] xb_p2, yb_p2, z_p2;

    logic signed [WIDTH-1:0] cos_w, sin_w;

    logic signed [WIDTH-1:0] cos_mem [DEPTH];
    logic signed [WIDTH-1:0] sin_mem [DEPTH];
    logic signed [WIDTH-1:0] z_mem   [DEPTH];
    logic        [ADDR_W-1:0] rd_ptr, wr_ptr, rd_next;
    logic        [ADDR_W:0]   count, count_next;
    logic                     pop, full, do_write;
    logic signed [WIDTH-1:0]  head_cos, head_sin, head_z;

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p0 <= 1'b0;
            vld_p1 <= 1'b0;
            vld_p2 <= 1'b0;
        end else begin
            vld_p0 <= valid_in;
            vld_p1 <= vld_p0;
            vld_p2 <= vld_p1;
        end
    end

    always_ff @(posedge clk) begin
        // p0: input capture
        x_p0    <= x_in;
        y_p0    <= y_in;
        z_p0    <= z_in;
        quad_p0 <= quad_in;
        // p1: gain part A
`ifdef CORDIC_GAIN_COMP_EN
        xa_p1   <= gain_a(x_p0);
        ya_p1   <= gain_a(y_p0);
        x_p1    <= x_p0;
        y_p1    <= y_p0;
`else
        xa_p1   <= x_p0;
        ya_p1   <= y_p0;
`endif
        z_p1    <= z_p0;
        quad_p1 <= quad_p0;
        // p2: gain part B
`ifdef CORDIC_GAIN_COMP_EN
        xb_p2   <= gain_b(xa_p1, x_p1);
        yb_p2   <= gain_b(ya_p1, y_p1);
`else
        xb_p2   <= xa_p1;
        yb_p2   <= ya_p1;
`endif
        z_p2    <= z_p1;
        quad_p2 <= quad_p1;
    end

    always_comb begin
        cos_w = xb_p2;
        sin_w = yb_p2;
        case (quad_p2)
            2'd1:    begin cos_w = neg(yb_p2); sin_w = xb_p2;      end
            2'd2:    begin cos_w = neg(xb_p2); sin_w = neg(yb_p2); end
            2'd3:    begin cos_w = yb_p2;      sin_w = neg(xb_p2); end
            default: begin cos_w = xb_p2;      sin_w = yb_p2;      end
        endcase
    end

    // A full FIFO still accepts a write when the head is popped on the same edge.
    always_comb begin
        pop        = (count != '0) && out_ready;
        full       = (count == FULL_CNT);
        do_write   = vld_p2 && (!full || pop);
        rd_next    = pop ? rd_ptr + ADDR_W'(1) : rd_ptr;
        count_next = count;
        if (do_write && !pop)
            count_next = count + (ADDR_W+1)'(1);
        else if (!do_write && pop)
            count_next = count - (ADDR_W+1)'(1);
        if (do_write && (wr_ptr == rd_next)) begin
            head_cos = cos_w;
            head_sin = sin_w;
            head_z   = z_p2;
        end else begin
            head_cos = cos_mem[rd_next];
            head_sin = sin_mem[rd_next];
            head_z   = z_mem[rd_next];
        end
    end

    always_ff @(posedge clk) begin
        if (do_write) begin
            cos_mem[wr_ptr] <= cos_w;
            sin_mem[wr_ptr] <= sin_w;
            z_mem[wr_ptr]   <= z_p2;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
            cos_out  <= '0;
            sin_out  <= '0;
            z_res    <= '0;
        end else begin
            rd_ptr <= rd_next;
            count  <= count_next;
            if (do_write)
                wr_ptr <= wr_ptr + ADDR_W'(1);
            if (vld_p2 && full && !pop)
                overflow <= 1'b1;
            // Registered head: holds its last value while the FIFO is empty.
            if (count_next != '0) begin
                cos_out <= head_cos;
                sin_out <= head_sin;
                z_res   <= head_z;
            end
        end
    end

    assign out_valid  = (count != '0);
    assign fifo_count = count;

endmodule

// File: doc/cordic_output_stage.md
Name: cordic_output_stage

Overview:
- Terminal stage of the pipelined CORDIC rotator; consumes the x/y/z result of the last shift-accumulate iteration.
- Applies CORDIC gain compensation (multiply by K ≈ 0.607254) using a 2-stage shift-add pipeline, then undoes the input quadrant pre-rotation.
- Buffers results in a small first-word-fall-through (FWFT) FIFO with valid/ready, because the iteration pipeline has no stall path.

Parameters:
- WIDTH, 32, datapath width; x/y are signed Q2.30, z is a signed angle.
- DEPTH, 4, output FIFO entries; must be a power of two, at least 2.
- ADDR_W, 2, log2(DEPTH); the count is ADDR_W+1 bits.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- valid_in  in  1  x_in/y_in/z_in/quad_in are valid this cycle
- x_in  in  WIDTH  final-iteration x, signed
- y_in  in  WIDTH  final-iteration y, signed
- z_in  in  WIDTH  residual angle, signed
- quad_in  in  2  pre-rotation tag carried down the pipeline
- out_ready  in  1  consumer accepts the head entry
- out_valid  out  1  FIFO non-empty
- cos_out  out  WIDTH  head entry cosine
- sin_out  out  WIDTH  head entry sine
- z_res  out  WIDTH  head entry residual angle
- fifo_count  out  ADDR_W+1  occupied entries
- overflow  out  1  sticky: a result was dropped

Behaviour:
- Clock and reset: single clock clk. rst is synchronous and active-high, sampled on the rising edge of clk.
- On reset:
  - all pipeline valid bits cleared, FIFO pointers and count set to 0;
  - out_valid=0, overflow=0, fifo_count=0;
  - cos_out/sin_out/z_res=0;
  - in-flight samples are discarded;
  - a valid_in asserted in the same cycle as rst is ignored.
- S1 (register), gain part A, on each of x and y (arithmetic right shifts):
  - a = (v>>>1) + (v>>>3) - (v>>>6) - (v>>>9).
- S2 (register), gain part B:
  - b = a - (v>>>13) - (v>>>15) - (v>>>16);
  - v is the original input, delayed alongside a.
- S3 (FIFO write), quadrant fix applied to (xs, ys) = S2 result:
  - quad 0: cos=xs, sin=ys
  - quad 1: cos=-ys, sin=xs
  - quad 2: cos=-xs, sin=-ys
  - quad 3: cos=ys, sin=-xs
- z and quad are delayed through S1/S2 unchanged; z_res = delayed z_in.
- Width rules:
  - all arithmetic is WIDTH-bit two's complement, wrap on overflow;
  - negation of the most negative value wraps (yields itself).
- Latency:
  - a sample with valid_in=1 at edge T is written to the FIFO at edge T+3;
  - out_valid and the result appear after edge T+3 when the FIFO was empty.
- Throughput: one sample per cycle, no bubbles.
- FIFO and handshake:
  - FWFT: the head entry is presented on cos_out/sin_out/z_res whenever out_valid=1.
  - A pop occurs on an edge with out_valid && out_ready.
  - Outputs must remain stable while out_valid && !out_ready.
  - While empty, outputs hold their last values; out_ready is ignored.
- Full / simultaneous events:
  - Write while full with no pop in the same edge: the sample is dropped, overflow is set, and FIFO contents are unchanged.
  - Write while full with a simultaneous pop: both happen; count unchanged, no overflow.
  - Write and pop on the same edge at other occupancies: count unchanged.
  - Pointers wrap modulo DEPTH.
- overflow stays high until rst.
- fifo_count always equals writes minus pops since reset, and never exceeds DEPTH.

Optional Feature:
- Macro: CORDIC_GAIN_COMP_EN.
- Defined: gain compensation as described above.
- Undefined:
  - S1/S2 pass x/y through unscaled (a=v, b=a);
  - latency stays 3 cycles;
  - quadrant fix and FIFO are unchanged.
- Downstream scaling is then the consumer's responsibility.

Test Plan:
- Reset, then one sample with x_in=0x40000000, y_in=0, z_in=0x00000010, quad 0, out_ready=1 -> out_valid rises exactly 3 edges later with cos_out=0x26DD4000, sin_out=0, z_res=0x00000010; one-cycle pulse.
- Same x/y with quad_in=1, 2, 3 -> (cos,sin) = (0,0x26DD4000), (0xD922C000,0), (0,0xD922C000).
- Build with CORDIC_GAIN_COMP_EN undefined, x_in=0x40000000, quad 0 -> cos_out=0x40000000 after 3 edges.
- out_ready=0, 6 back-to-back samples with distinct x, DEPTH=4 -> fifo_count reaches 4, samples 5 and 6 dropped, overflow=1; raise out_ready -> first 4 samples emerge in order, overflow stays 1.
- FIFO full, out_ready=1 on the same edge as an incoming write -> head pops, new sample enqueued, fifo_count stays 4, overflow stays 0.
- Assert rst for 1 cycle with 2 samples in S1/S2 and 3 in the FIFO -> out_valid=0, fifo_count=0 the next cycle; no in-flight sample ever appears.
